// File: rtl/excl_mon_pkg.sv
// Shared types and helpers for the AHB exclusive-access monitor.
package excl_mon_pkg;

  // Which kind of data phase the upstream port is in.
  typedef enum logic [1:0] {
    DP_IDLE = 2'd0,
    DP_FWD  = 2'd1,
    DP_FAIL = 2'd2
  } dp_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Reservation granule index of a byte address; callers slice the low bits.
  function automatic logic [63:0] granule(input logic [63:0] addr, input int unsigned glog2);
    return addr >> glog2;
  endfunction

endpackage

// File: rtl/excl_res_slot.sv
// One LR reservation: valid bit, granule address and, with EXCL_MON_TIMEOUT_EN,
// an expiry down-counter.
module excl_res_slot
  import excl_mon_pkg::*;
#(
  parameter int W_G         = 30,
  parameter int RES_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           set,         // exclusive read by this slot's master
  input  logic           clr_own,     // exclusive write by this slot's master
  input  logic           snoop_wr,    // some write is being forwarded downstream
  input  logic           freeze,      // own exclusive write under evaluation
  input  logic [W_G-1:0] addr,        // granule loaded on set, compared for match
  input  logic [W_G-1:0] snoop_addr,  // granule of the forwarded write
  output logic           match
);

  logic           valid_q, valid_d;
  logic [W_G-1:0] gran_q, gran_d;
  logic           snoop_hit;

  assign match     = valid_q && (gran_q == addr);
  assign snoop_hit = valid_q && (gran_q == snoop_addr);

`ifdef EXCL_MON_TIMEOUT_EN
  localparam int CNT_W = ($clog2(RES_TIMEOUT + 1) > 8) ? $clog2(RES_TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next reservation state: set wins, then explicit clears, then expiry.
  always_comb begin
    valid_d = valid_q;
    gran_d  = gran_q;
    cnt_d   = cnt_q;
    if (set) begin
      valid_d = 1'b1;
      gran_d  = addr;
      cnt_d   = CNT_W'(RES_TIMEOUT);
    end else if (clr_own || (snoop_wr && snoop_hit)) begin
      valid_d = 1'b0;
    end else if (valid_q && !freeze) begin
      if (cnt_q == '0) valid_d = 1'b0;
      else             cnt_d   = cnt_q - 1'b1;
    end
  end

  // Expiry counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_freeze;
  assign unused_freeze = freeze;

  // Next reservation state: set wins over clears; no expiry.
  always_comb begin
    valid_d = valid_q;
    gran_d  = gran_q;
    if (set) begin
      valid_d = 1'b1;
      gran_d  = addr;
    end else if (clr_own || (snoop_wr && snoop_hit)) begin
      valid_d = 1'b0;
    end
  end
`endif

  // Reservation register; reset drops every reservation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      gran_q  <= '0;
    end else begin
      valid_q <= valid_d;
      gran_q  <= gran_d;
    end
  end

endmodule

// File: rtl/ahb_excl_monitor.sv
// AHB-lite exclusive-access monitor in front of a plain memory slave.
// Tracks one LR reservation per master, forwards legal transfers untouched
// and turns failing store-conditionals into IDLE downstream, answering them
// locally with hexokay=0. Optional reservation expiry: EXCL_MON_TIMEOUT_EN.
module ahb_excl_monitor
  import excl_mon_pkg::*;
#(
  parameter int W_ADDR       = 32,
  parameter int W_DATA       = 32,
  parameter int N_MASTERS    = 2,
  parameter int GRANULE_LOG2 = 2,
  parameter int RES_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // upstream slave port
  output logic              ahbls_hready_resp,
  input  logic              ahbls_hready,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [2:0]        ahbls_hburst,
  input  logic [3:0]        ahbls_hprot,
  input  logic              ahbls_hmastlock,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata,
  input  logic              ahbls_hexcl,
  input  logic [7:0]        ahbls_hmaster,
  output logic              ahbls_hexokay,
  // downstream master port
  output logic [W_ADDR-1:0] ahblm_haddr,
  output logic              ahblm_hwrite,
  output logic [1:0]        ahblm_htrans,
  output logic [2:0]        ahblm_hsize,
  output logic [2:0]        ahblm_hburst,
  output logic [3:0]        ahblm_hprot,
  output logic              ahblm_hmastlock,
  output logic [W_DATA-1:0] ahblm_hwdata,
  output logic              ahblm_hready,
  output logic              ahblm_hexcl,
  output logic [7:0]        ahblm_hmaster,
  input  logic              ahblm_hready_resp,
  input  logic              ahblm_hresp,
  input  logic [W_DATA-1:0] ahblm_hrdata,
  input  logic              ahblm_hexokay
);

  localparam int W_G = W_ADDR - GRANULE_LOG2;

  dp_state_e            state_q, state_d;
  logic                 exokay_q, exokay_d;
  logic [63:0]          g64;
  logic [W_G-1:0]       addr_g;
  logic [N_MASTERS-1:0] own_oh, match_vec;
  logic                 aphase, in_range, own_match;
  logic                 excl_rd, excl_wr, sc_pass, sc_fail, fwd_wr;

  assign g64    = granule(64'(ahbls_haddr), GRANULE_LOG2);
  assign addr_g = g64[W_G-1:0];

  logic unused_ok;
  assign unused_ok = ^{g64[63:W_G], ahblm_hexokay};

  // Decode of the accepted address phase.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) own_oh[i] = (ahbls_hmaster == 8'(i));
    aphase    = ahbls_htrans[1] && ahbls_hready;
    in_range  = |own_oh;
    own_match = |(own_oh & match_vec);
    excl_rd   = aphase && ahbls_hexcl && !ahbls_hwrite;
    excl_wr   = aphase && ahbls_hexcl &&  ahbls_hwrite;
    sc_pass   = excl_wr &&  own_match;
    sc_fail   = excl_wr && !own_match;
    fwd_wr    = aphase && ahbls_hwrite && !sc_fail;
  end

  // Reservation slots, one per master.
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_slot
    excl_res_slot #(
      .W_G         (W_G),
      .RES_TIMEOUT (RES_TIMEOUT)
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .set        (excl_rd && own_oh[i]),
      .clr_own    (excl_wr && own_oh[i]),
      .snoop_wr   (fwd_wr),
      .freeze     (excl_wr && own_oh[i]),
      .addr       (addr_g),
      .snoop_addr (addr_g),
      .match      (match_vec[i])
    );
  end

  // Address phase passes straight through; a failing SC becomes IDLE.
  assign ahblm_haddr     = ahbls_haddr;
  assign ahblm_hwrite    = ahbls_hwrite;
  assign ahblm_htrans    = sc_fail ? HTRANS_IDLE : ahbls_htrans;
  assign ahblm_hsize     = ahbls_hsize;
  assign ahblm_hburst    = ahbls_hburst;
  assign ahblm_hprot     = ahbls_hprot;
  assign ahblm_hmastlock = ahbls_hmastlock;
  assign ahblm_hwdata    = ahbls_hwdata;
  assign ahblm_hready    = ahbls_hready;
  assign ahblm_hexcl     = 1'b0;
  assign ahblm_hmaster   = ahbls_hmaster;

  // Data-phase kind and exclusive-okay for the next data phase.
  always_comb begin
    state_d  = state_q;
    exokay_d = exokay_q;
    if (ahbls_hready) begin
      if (!aphase)      state_d = DP_IDLE;
      else if (sc_fail) state_d = DP_FAIL;
      else              state_d = DP_FWD;
      exokay_d = sc_pass || (excl_rd && in_range);
    end
  end

  // Data-phase state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DP_IDLE;
      exokay_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      exokay_q <= exokay_d;
    end
  end

  // Upstream response: downstream data only in forwarded data phases.
  assign ahbls_hready_resp = ahblm_hready_resp;
  assign ahbls_hrdata      = (state_q == DP_FWD) ? ahblm_hrdata : '0;
  assign ahbls_hresp       = (state_q == DP_FWD) ? ahblm_hresp  : 1'b0;
  assign ahbls_hexokay     = exokay_q;

endmodule
